// File: rtl/latch_write_arbiter.sv
// Round-robin arbiter that owns a shared D-latch bank and sequences SETUP -> ENABLE -> HOLD.
// Optional LATCH_ARB_CHECK_EN adds a lat_q readback compare that reports through wr_err.
module latch_write_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned DW        = 8,
    parameter int unsigned EN_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    ack,
    output logic               busy,
    output logic [DW-1:0]      lat_d,
    output logic               lat_e
`ifdef LATCH_ARB_CHECK_EN
    ,
    input  logic [DW-1:0]      lat_q,
    output logic [NREQ-1:0]    wr_err
`endif
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = $clog2(EN_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ENABLE = 2'd2,
        S_HOLD   = 2'd3
    } state_e;

    state_e          state_q;
    logic [PW-1:0]   ptr_q;
    logic [CW-1:0]   cnt_q;
    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] ack_q;
    logic            busy_q;
    logic [DW-1:0]   lat_d_q;
    logic            lat_e_q;

    logic            win_vld_c;
    logic [PW-1:0]   win_idx_c;
    logic [PW-1:0]   ptr_nxt_c;
    logic [DW-1:0]   win_data_c;
    logic            en_last_c;

    // (base + off) mod NREQ, valid for off < NREQ
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return PW'(s);
    endfunction

    // First requester found when searching upward from ptr_q
    always_comb begin
        win_vld_c = 1'b0;
        win_idx_c = '0;
        for (int unsigned o = 0; o < NREQ; o++) begin
            if (!win_vld_c && req[wrap_add(ptr_q, o)]) begin
                win_vld_c = 1'b1;
                win_idx_c = wrap_add(ptr_q, o);
            end
        end
        ptr_nxt_c  = wrap_add(win_idx_c, 1);
        win_data_c = wdata[32'(win_idx_c)*DW +: DW];
        en_last_c  = (state_q == S_ENABLE) && (cnt_q == CW'(EN_CYCLES));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            lat_d_q <= '0;
            lat_e_q <= 1'b0;
        end else begin
            ack_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (win_vld_c) begin
                        state_q <= S_SETUP;
                        gnt_q   <= NREQ'(1) << win_idx_c;
                        lat_d_q <= win_data_c;
                        busy_q  <= 1'b1;
                        ptr_q   <= ptr_nxt_c;
                    end
                end
                S_SETUP: begin
                    state_q <= S_ENABLE;
                    lat_e_q <= 1'b1;
                    cnt_q   <= CW'(1);
                end
                S_ENABLE: begin
                    if (en_last_c) begin
                        state_q <= S_HOLD;
                        lat_e_q <= 1'b0;
                        ack_q   <= gnt_q;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_HOLD: begin
                    state_q <= S_IDLE;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef LATCH_ARB_CHECK_EN
    logic [NREQ-1:0] wr_err_q;

    // The bank is transparent in the last ENABLE cycle, so Q must match d at that edge;
    // sampling there lets the error pulse line up with ack in HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err_q <= '0;
        end else begin
            wr_err_q <= (en_last_c && (lat_q != lat_d_q)) ? gnt_q : '0;
        end
    end

    assign wr_err = wr_err_q;
`endif

    assign gnt   = gnt_q;
    assign ack   = ack_q;
    assign busy  = busy_q;
    assign lat_d = lat_d_q;
    assign lat_e = lat_e_q;

endmodule
